// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven segment display.
// Drives one shared BCD decoder plus one-hot active-low digit selects; updates land on frame boundaries.
module sevenseg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    upd_valid,
   output logic                    upd_ready,
   input  logic [4*NUM_DIGITS-1:0] upd_data,
   input  logic [NUM_DIGITS-1:0]   upd_dp,
   input  logic                    lz_suppress,
   output logic [3:0]              bcd,
   output logic [NUM_DIGITS-1:0]   digit_sel_n,
   output logic                    dp_n,
   output logic                    frame_done
);

   // state    | meaning
   // ST_OFF   | scanning disabled; counter and index parked at 0
   // ST_BLANK | slot counter in the anti-ghosting window, all digits off
   // ST_SHOW  | slot counter past the blank window, digit idx lit

   localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam int IDX_W = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;

   logic [4*NUM_DIGITS-1:0] active_data, active_data_d;
   logic [NUM_DIGITS-1:0]   active_dp, active_dp_d;
   logic [4*NUM_DIGITS-1:0] pend_data, pend_data_d;
   logic [NUM_DIGITS-1:0]   pend_dp, pend_dp_d;
   logic                    pend_flag, pend_flag_d;

   logic [3:0]              bcd_d;
   logic [NUM_DIGITS-1:0]   digit_sel_n_d;
   logic                    dp_n_d;
   logic                    frame_done_d;
   logic                    upd_ready_d;

   logic                    slot_end;
   logic                    frame_end;
   logic                    xfer;
   logic                    swap;
   logic [3:0]              cur_digit;
   logic [NUM_DIGITS-1:0]   sel_onehot;
   logic [NUM_DIGITS-1:0]   supp;
   logic                    lead;

   // A digit is a leading zero when it and every more significant digit are zero.
   always_comb begin
      lead = 1'b1;
      supp = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         lead    = lead & (active_data[4*i +: 4] == 4'h0);
         supp[i] = lead;
      end
   end

   always_comb begin
      cur_digit           = active_data[4*idx_q +: 4];
      sel_onehot          = '0;
      sel_onehot[idx_q]   = 1'b1;
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      idx_d         = idx_q;
      active_data_d = active_data;
      active_dp_d   = active_dp;
      pend_data_d   = pend_data;
      pend_dp_d     = pend_dp;
      pend_flag_d   = pend_flag;
      bcd_d         = 4'hF;
      digit_sel_n_d = '1;
      dp_n_d        = 1'b1;
      frame_done_d  = 1'b0;
      swap          = 1'b0;

      slot_end  = (cnt_q == CNT_LAST);
      frame_end = slot_end && (idx_q == IDX_LAST);
      xfer      = upd_valid && upd_ready;

      if (enable) begin
         if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         frame_done_d = frame_end;
         swap         = pend_flag && frame_end;
      end else begin
         cnt_d = '0;
         idx_d = '0;
         swap  = pend_flag;
      end

      if (!enable)
         state_d = ST_OFF;
      else if (cnt_d < CNT_BLANK)
         state_d = ST_BLANK;
      else
         state_d = ST_SHOW;

      if (swap) begin
         active_data_d = pend_data;
         active_dp_d   = pend_dp;
         pend_flag_d   = 1'b0;
      end
      // ready is low whenever the flag is set, so a capture never collides with a swap.
      if (xfer) begin
         pend_data_d = upd_data;
         pend_dp_d   = upd_dp;
         pend_flag_d = 1'b1;
      end

      // Ready stays low through the swap cycle and reopens one cycle later.
      upd_ready_d = ~(pend_flag | pend_flag_d);

      if (enable && (state_q == ST_SHOW)) begin
         digit_sel_n_d = ~sel_onehot;
         bcd_d         = (lz_suppress && supp[idx_q]) ? 4'hF : cur_digit;
         dp_n_d        = ~active_dp[idx_q];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_OFF;
         cnt_q       <= '0;
         idx_q       <= '0;
         active_data <= '0;
         active_dp   <= '0;
         pend_data   <= '0;
         pend_dp     <= '0;
         pend_flag   <= 1'b0;
         bcd         <= 4'hF;
         digit_sel_n <= '1;
         dp_n        <= 1'b1;
         frame_done  <= 1'b0;
         upd_ready   <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         active_data <= active_data_d;
         active_dp   <= active_dp_d;
         pend_data   <= pend_data_d;
         pend_dp     <= pend_dp_d;
         pend_flag   <= pend_flag_d;
         bcd         <= bcd_d;
         digit_sel_n <= digit_sel_n_d;
         dp_n        <= dp_n_d;
         frame_done  <= frame_done_d;
         upd_ready   <= upd_ready_d;
      end
   end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
module tb_sevenseg_scan_ctrl;

   localparam int ND = 4;
   localparam int PS = 8;
   localparam int BC = 2;
   localparam int FRAME = ND * PS;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        upd_valid;
   logic        upd_ready;
   logic [15:0] upd_data;
   logic [3:0]  upd_dp;
   logic        lz_suppress;
   logic [3:0]  bcd;
   logic [3:0]  digit_sel_n;
   logic        dp_n;
   logic        frame_done;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sevenseg_scan_ctrl #(
      .NUM_DIGITS  (ND),
      .PRESCALE    (PS),
      .BLANK_CYCLES(BC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .upd_valid  (upd_valid),
      .upd_ready  (upd_ready),
      .upd_data   (upd_data),
      .upd_dp     (upd_dp),
      .lz_suppress(lz_suppress),
      .bcd        (bcd),
      .digit_sel_n(digit_sel_n),
      .dp_n       (dp_n),
      .frame_done (frame_done)
   );

   typedef struct packed {
      logic [15:0] data;
      logic [3:0]  dp;
      logic        lz;
      logic [15:0] exp_nib;  // expected bcd per idx, nibble i = idx i
      logic [3:0]  exp_dp;   // idx whose dp_n must be low while shown
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // k counts negedges since the first clock edge that saw enable high.
   task automatic check_cycle(input int k, input logic [15:0] nib, input logic [3:0] dpm);
      int         slot;
      int         c;
      logic [3:0] esel;
      logic [3:0] ebcd;
      logic       edp;
      logic       efd;
      slot = (k / PS) % ND;
      c    = k % PS;
      if (c < BC) begin
         esel = 4'hF;
         ebcd = 4'hF;
         edp  = 1'b1;
      end else begin
         esel = ~(4'b0001 << slot);
         ebcd = nib[slot*4 +: 4];
         edp  = ~dpm[slot];
      end
      efd = ((k % FRAME) == FRAME - 1);
      chk($sformatf("sel k=%0d", k), 16'(digit_sel_n), 16'(esel));
      chk($sformatf("bcd k=%0d", k), 16'(bcd), 16'(ebcd));
      chk($sformatf("dp_n k=%0d", k), 16'(dp_n), 16'(edp));
      chk($sformatf("frame_done k=%0d", k), 16'(frame_done), 16'(efd));
   endtask

   task automatic check_off(input string tag);
      chk({tag, " sel"}, 16'(digit_sel_n), 16'h000F);
      chk({tag, " bcd"}, 16'(bcd), 16'h000F);
      chk({tag, " dp_n"}, 16'(dp_n), 16'h0001);
      chk({tag, " frame_done"}, 16'(frame_done), 16'h0000);
   endtask

   // With enable low a captured value swaps into active on the following edge.
   task automatic load_offline(input logic [15:0] d, input logic [3:0] dp);
      int t;
      t = 0;
      while (upd_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("load ready before offer", 16'(upd_ready), 16'h0001);
      upd_data  = d;
      upd_dp    = dp;
      upd_valid = 1'b1;
      @(negedge clk);
      chk("load ready after capture", 16'(upd_ready), 16'h0000);
      upd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("load ready after swap", 16'(upd_ready), 16'h0001);
   endtask

   initial begin
      vecs[0] = '{16'h0000, 4'b0000, 1'b0, 16'h0000, 4'b0000};
      vecs[1] = '{16'h1234, 4'b0000, 1'b0, 16'h1234, 4'b0000};
      vecs[2] = '{16'h0050, 4'b0000, 1'b1, 16'hFF50, 4'b0000};
      vecs[3] = '{16'h0000, 4'b0000, 1'b1, 16'hFFF0, 4'b0000};
      vecs[4] = '{16'h0050, 4'b0100, 1'b1, 16'hFF50, 4'b0100};
      vecs[5] = '{16'hABCD, 4'b1001, 1'b0, 16'hABCD, 4'b1001};
      vecs[6] = '{16'h0705, 4'b0000, 1'b1, 16'hF705, 4'b0000};
      vecs[7] = '{16'h000A, 4'b0010, 1'b1, 16'hFFFA, 4'b0010};

      reset       = 1'b1;
      enable      = 1'b0;
      upd_valid   = 1'b0;
      upd_data    = 16'h0000;
      upd_dp      = 4'h0;
      lz_suppress = 1'b0;
      repeat (3) @(negedge clk);
      check_off("reset");
      chk("reset upd_ready", 16'(upd_ready), 16'h0001);
      reset = 1'b0;
      @(negedge clk);

      // Table-driven frames, one full frame per vector.
      for (int i = 0; i < 8; i++) begin
         enable = 1'b0;
         @(negedge clk);
         load_offline(vecs[i].data, vecs[i].dp);
         lz_suppress = vecs[i].lz;
         enable      = 1'b1;
         for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            check_cycle(k, vecs[i].exp_nib, vecs[i].exp_dp);
         end
      end

      // Mid-frame update: current frame keeps old data, next frame shows new.
      enable = 1'b0;
      lz_suppress = 1'b0;
      @(negedge clk);
      load_offline(16'h0000, 4'h0);
      enable = 1'b1;
      for (int k = 0; k < 2 * FRAME; k++) begin
         @(negedge clk);
         check_cycle(k, (k < FRAME) ? 16'h0000 : 16'h1234, 4'h0);
         if (k == 10) begin
            chk("mid ready before offer", 16'(upd_ready), 16'h0001);
            upd_data  = 16'h1234;
            upd_valid = 1'b1;
         end
         if (k == 11) begin
            chk("mid ready drops", 16'(upd_ready), 16'h0000);
            upd_valid = 1'b0;
         end
         if (k == FRAME - 1) chk("mid ready at frame_done", 16'(upd_ready), 16'h0000);
         if (k == FRAME)     chk("mid ready returns", 16'(upd_ready), 16'h0001);
      end

      // Back-to-back offers with valid held: second stalls until the swap.
      enable = 1'b0;
      @(negedge clk);
      load_offline(16'h0000, 4'h0);
      enable = 1'b1;
      for (int k = 0; k < 3 * FRAME; k++) begin
         @(negedge clk);
         check_cycle(k, (k < FRAME) ? 16'h0000 : (k < 2 * FRAME) ? 16'h1111 : 16'h2222, 4'h0);
         if (k == 3) begin
            upd_data  = 16'h1111;
            upd_valid = 1'b1;
         end
         if (k == 4) begin
            chk("b2b first accepted", 16'(upd_ready), 16'h0000);
            upd_data = 16'h2222;
         end
         if (k == FRAME - 1) chk("b2b stalled at swap", 16'(upd_ready), 16'h0000);
         if (k == FRAME)     chk("b2b ready after swap", 16'(upd_ready), 16'h0001);
         if (k == FRAME + 1) begin
            chk("b2b second accepted", 16'(upd_ready), 16'h0000);
            upd_valid = 1'b0;
         end
         if (k == 2 * FRAME) chk("b2b ready after second swap", 16'(upd_ready), 16'h0001);
      end

      // Enable drop mid-slot, restart at slot 0, then reset mid-frame.
      enable = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         check_cycle(k, 16'h2222, 4'h0);
      end
      enable = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check_off($sformatf("disabled j=%0d", j));
      end
      enable = 1'b1;
      for (int k = 0; k < 21; k++) begin
         @(negedge clk);
         check_cycle(k, 16'h2222, 4'h0);
         if (k == 15) begin
            chk("pre-reset ready", 16'(upd_ready), 16'h0001);
            upd_data  = 16'h9999;
            upd_valid = 1'b1;
         end
         if (k == 16) begin
            chk("pre-reset captured", 16'(upd_ready), 16'h0000);
            upd_valid = 1'b0;
         end
      end
      reset = 1'b1;
      @(negedge clk);
      check_off("midframe reset");
      chk("midframe reset upd_ready", 16'(upd_ready), 16'h0001);
      reset = 1'b0;
      for (int k = 0; k < 2 * FRAME; k++) begin
         @(negedge clk);
         check_cycle(k, 16'h0000, 4'h0);
         if (k == 0) chk("post-reset ready", 16'(upd_ready), 16'h0001);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
